// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan path.
//   SEG7_MAX_DIGITS : widest display the scan mux supports
//   digit_idx_t     : scan slot index, wide enough for SEG7_MAX_DIGITS
//   onehot_n()      : active-low one-hot digit select for a slot index
package seg7_pkg;

  localparam int unsigned SEG7_MAX_DIGITS = 8;

  typedef logic [$clog2(SEG7_MAX_DIGITS)-1:0] digit_idx_t;

  // Bits at or above 'digits' always stay high, so callers may truncate freely.
  function automatic logic [SEG7_MAX_DIGITS-1:0] onehot_n(input digit_idx_t idx,
                                                          input int unsigned digits);
    logic [SEG7_MAX_DIGITS-1:0] sel;
    sel = '1;
    for (int unsigned i = 0; i < SEG7_MAX_DIGITS; i++) begin
      if ((i < digits) && (digit_idx_t'(i) == idx)) sel[i] = 1'b0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_tick.sv
// scan_tick_gen: free-running divider that produces one scan tick per
// TICK_DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for the single cycle the count sits at TICK_DIV-1
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes a DIGITS-nibble hex value onto one shared
// hex-to-seven-segment decoder. New values are double-buffered and only reach
// the display register at a scan-frame boundary, so a frame never tears.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   disp_en      : 1 = drive scanning selects, 0 = all selects deasserted
//   load_valid   : one-cycle strobe capturing load_data
//   load_data    : new value, digit 0 in bits [3:0]
//   pending      : a captured value waits for the frame boundary
//   digit_nibble : nibble of the current slot (decoder input)
//   digit_sel    : active-low one-hot select of the current digit
//   digit_blank  : decoder output for this slot must be forced off
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits; otherwise digit_blank is constant 0.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_en,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  pending,
  output logic [3:0]            digit_nibble,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  digit_blank
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(DIGITS - 1);

  logic                tick;
  logic                frame_end;
  digit_idx_t          idx_q;
  logic [4*DIGITS-1:0] display_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic [3:0]          nibble_next;
  logic [DIGITS-1:0]   sel_next;
  logic                blank_next;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_end = tick && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (tick) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + digit_idx_t'(1);
    end
  end

  // A load landing on the boundary bypasses the shadow entirely; an older
  // shadow is simply abandoned by clearing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
      shadow_q  <= '0;
      pending   <= 1'b0;
    end else if (frame_end) begin
      if (load_valid) begin
        display_q <= load_data;
      end else if (pending) begin
        display_q <= shadow_q;
      end
      pending <= 1'b0;
    end else if (load_valid) begin
      shadow_q <= load_data;
      pending  <= 1'b1;
    end
  end

  always_comb begin
    nibble_next = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (idx_q == digit_idx_t'(d)) nibble_next = display_q[4*d +: 4];
    end
  end

  always_comb begin
    sel_next = '1;
    if (disp_en) sel_next = DIGITS'(onehot_n(idx_q, DIGITS));
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  digit_idx_t top_nz;

  // Highest nonzero digit; stays 0 for an all-zero value so digit 0 shows.
  always_comb begin
    top_nz = '0;
    for (int unsigned d = 1; d < DIGITS; d++) begin
      if (display_q[4*d +: 4] != 4'h0) top_nz = digit_idx_t'(d);
    end
    blank_next = (idx_q > top_nz);
  end
`else
  always_comb begin
    blank_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_nibble <= '0;
      digit_sel    <= {{(DIGITS-1){1'b1}}, 1'b0};
      digit_blank  <= 1'b0;
    end else begin
      digit_nibble <= nibble_next;
      digit_sel    <= sel_next;
      digit_blank  <= blank_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed plus randomized stimulus for seg7_scan_mux with
// DIGITS=4, TICK_DIV=4, checked against a cycle-count reference model.
module tb_seg7_scan_mux;

  localparam int unsigned DIG   = 4;
  localparam int unsigned TDIV  = 4;
  localparam int unsigned FRAME = DIG * TDIV;

  logic          clk;
  logic          rst_n;
  logic          disp_en;
  logic          load_valid;
  logic [15:0]   load_data;
  logic          pending;
  logic [3:0]    digit_nibble;
  logic [3:0]    digit_sel;
  logic          digit_blank;

  int unsigned total;
  int unsigned bad;

  // Reference model: n = clock edges since reset release.
  int unsigned n;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic [3:0]  e_nib;
  logic [3:0]  e_sel;
  logic        e_blank;

  seg7_scan_mux #(
    .DIGITS   (DIG),
    .TICK_DIV (TDIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_en      (disp_en),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .pending      (pending),
    .digit_nibble (digit_nibble),
    .digit_sel    (digit_sel),
    .digit_blank  (digit_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s at n=%0d: got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int unsigned d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic blank_of(input logic [15:0] v, input int unsigned slot);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    int unsigned hi;
    hi = 0;
    for (int unsigned d = 0; d < DIG; d++) if (nib_of(v, d) != 4'h0) hi = d;
    return slot > hi;
`else
    return (v != v) && (slot > DIG);
`endif
  endfunction

  task automatic model_reset();
    n        = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},     {12'h0, digit_sel},   16'h000E);
    chk({tag, "_nib"},     {12'h0, digit_nibble}, 16'h0000);
    chk({tag, "_blank"},   {15'h0, digit_blank}, 16'h0000);
    chk({tag, "_pending"}, {15'h0, pending},     16'h0000);
  endtask

  // One clock with the given inputs; model updated from the specification's
  // rules, then all outputs checked 1 ns after the edge.
  task automatic step(input logic lv, input logic [15:0] ld, input logic en);
    int unsigned slot;
    logic [3:0]  oh;
    load_valid = lv;
    load_data  = ld;
    disp_en    = en;
    @(posedge clk);
    slot    = (n / TDIV) % DIG;
    oh      = 4'b0001 << slot;
    e_sel   = en ? ~oh : 4'hF;
    e_nib   = nib_of(m_disp, slot);
    e_blank = blank_of(m_disp, slot);
    if ((n % FRAME) == FRAME - 1) begin
      if (lv) m_disp = ld;
      else if (m_pend) m_disp = m_shadow;
      m_pend = 1'b0;
    end else if (lv) begin
      m_shadow = ld;
      m_pend   = 1'b1;
    end
    n++;
    #1;
    chk("sel",     {12'h0, digit_sel},    {12'h0, e_sel});
    chk("nibble",  {12'h0, digit_nibble}, {12'h0, e_nib});
    chk("blank",   {15'h0, digit_blank},  {15'h0, e_blank});
    chk("pending", {15'h0, pending},      {15'h0, m_pend});
    load_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, 16'h0, 1'b1);
  endtask

  // Advance so the next step's edge is the one at frame phase p.
  task automatic goto_phase(input int unsigned p);
    for (int unsigned i = 0; i < FRAME && (n % FRAME) != p; i++) step(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    disp_en    = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    model_reset();

    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: selects rotate every TDIV clocks, nibble 0.
    idle(2 * FRAME + 3);

    // Mid-frame load, held in shadow until the boundary.
    goto_phase(5);
    step(1'b1, 16'h1234, 1'b1);
    idle(2 * FRAME);

    // Last write wins; 0xAAAA must never reach the display.
    goto_phase(2);
    step(1'b1, 16'hAAAA, 1'b1);
    idle(5);
    step(1'b1, 16'h5678, 1'b1);
    idle(2 * FRAME);

    // Load exactly on the boundary edge: bypass, pending never rises.
    goto_phase(FRAME - 1);
    step(1'b1, 16'h9ABC, 1'b1);
    idle(FRAME + 2);

    // Display disabled: selects all high, scan keeps running.
    goto_phase(6);
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b0);
    idle(FRAME);

    // Leading-zero patterns.
    step(1'b1, 16'h0040, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h7000, 1'b1);
    idle(2 * FRAME);

    // Randomized loads and display enable.
    for (int unsigned i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 5) != 0));
    end
    idle(FRAME);

    // Asynchronous reset mid-slot with a value pending.
    goto_phase(3);
    step(1'b1, 16'hDEAD, 1'b1);
    idle(1);
    chk("pre_reset_pending", {15'h0, pending}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("async");
    @(posedge clk);
    #1;
    chk_reset_vals("held");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * FRAME + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
